health_manager: RTL

Upstream feeder of the status bar. Converts per-player hit events from collision/attack logic into the two 9-bit health values the health-bar renderer consumes. Sequences a round through fight, KO and round-over, and holds KO until the renderer's animated (final) health has drained to zero. Outputs also drive the game-state logic (winner, round over).

---
 rtl/health_pkg.sv | 30 +++
 rtl/health_manager_if.sv | 38 +++
 rtl/health_manager_player_health.sv | 67 ++++++
 rtl/health_manager.sv | 109 ++++++++++
 4 files changed

// File: rtl/health_pkg.sv
`default_nettype none
// ============================================================================
// Module   : health_pkg
// Brief    : Shared round-state, attack-code and winner encodings.
// Revision : 1.0 - initial release
// ============================================================================
package health_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_FIGHT      = 3'd1,
        ST_KO_WAIT    = 3'd2,
        ST_KO_HOLD    = 3'd3,
        ST_ROUND_OVER = 3'd4
    } state_t;

    localparam logic [1:0] ATK_NONE    = 2'b00;
    localparam logic [1:0] ATK_PUNCH   = 2'b01;
    localparam logic [1:0] ATK_KICK    = 2'b10;
    localparam logic [1:0] ATK_SPECIAL = 2'b11;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/health_manager_if.sv
`default_nettype none
// ============================================================================
// Module   : health_manager_if
// Brief    : Hit events, status-bar feedback and round status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface health_manager_if;
    logic       round_start;
    logic       hit_l;
    logic [1:0] atk_l;
    logic       block_l;
    logic       hit_r;
    logic [1:0] atk_r;
    logic       block_r;
    logic [8:0] final_health_l;
    logic [8:0] final_health_r;
    logic [8:0] curr_health_l;
    logic [8:0] curr_health_r;
    logic       fight_active;
    logic       ko_active;
    logic       round_over;
    logic [1:0] winner;

    modport master (
        output round_start, hit_l, atk_l, block_l, hit_r, atk_r, block_r,
               final_health_l, final_health_r,
        input  curr_health_l, curr_health_r, fight_active, ko_active,
               round_over, winner
    );

    modport slave (
        input  round_start, hit_l, atk_l, block_l, hit_r, atk_r, block_r,
               final_health_l, final_health_r,
        output curr_health_l, curr_health_r, fight_active, ko_active,
               round_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/health_manager_player_health.sv
`default_nettype none
// ============================================================================
// Module   : player_health
// Brief    : One player's health register, damage lookup and iframe timer.
// Revision : 1.0 - initial release
// ============================================================================
module player_health #(
    parameter logic [8:0]  MAX_HEALTH    = 9'd300,
    parameter logic [8:0]  DMG_PUNCH     = 9'd10,
    parameter logic [8:0]  DMG_KICK      = 9'd15,
    parameter logic [8:0]  DMG_SPECIAL   = 9'd30,
    parameter logic [23:0] IFRAME_CYCLES = 24'd5_000_000
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       hit,
    input  wire logic [1:0] atk,
    input  wire logic       block,
    input  wire logic       enable,
    input  wire logic       reload,
    output logic      [8:0] health,
    output logic            is_zero
);
    import health_pkg::*;

    logic [8:0]  r_health;
    logic [23:0] r_iframe;
    logic [8:0]  w_dmg_raw;
    logic [8:0]  w_dmg;
    logic [8:0]  w_health_sub;
    logic        w_hit_ok;

    always_comb begin
        w_dmg_raw = '0;
        case (atk)
            ATK_PUNCH:   w_dmg_raw = DMG_PUNCH;
            ATK_KICK:    w_dmg_raw = DMG_KICK;
            ATK_SPECIAL: w_dmg_raw = DMG_SPECIAL;
            default:     w_dmg_raw = '0;
        endcase
    end

    assign w_dmg        = block ? (w_dmg_raw >> 1) : w_dmg_raw;
    assign w_hit_ok     = enable && hit && (atk != ATK_NONE) && (r_iframe == '0);
    // Saturate at zero rather than wrapping into a large health value
    assign w_health_sub = (r_health > w_dmg) ? (r_health - w_dmg) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_health <= MAX_HEALTH;
            r_iframe <= '0;
        end else if (reload) begin
            r_health <= MAX_HEALTH;
            r_iframe <= '0;
        end else if (w_hit_ok) begin
            r_health <= w_health_sub;
            r_iframe <= IFRAME_CYCLES - 24'd1;
        end else if (r_iframe != '0) begin
            r_iframe <= r_iframe - 24'd1;
        end
    end

    assign health  = r_health;
    assign is_zero = (r_health == '0);

endmodule
`default_nettype wire

// File: rtl/health_manager.sv
`default_nettype none
// ============================================================================
// Module   : health_manager
// Brief    : Round sequencer (fight / KO / round over) over two health trackers.
// Revision : 1.0 - initial release
// ============================================================================
module health_manager #(
    parameter logic [8:0]  MAX_HEALTH     = 9'd300,
    parameter logic [8:0]  DMG_PUNCH      = 9'd10,
    parameter logic [8:0]  DMG_KICK       = 9'd15,
    parameter logic [8:0]  DMG_SPECIAL    = 9'd30,
    parameter logic [23:0] IFRAME_CYCLES  = 24'd5_000_000,
    parameter logic [27:0] KO_HOLD_CYCLES = 28'd200_000_000
) (
    input wire logic          clk,
    input wire logic          reset_n,
    health_manager_if.slave   hm
);
    import health_pkg::*;

    state_t      r_state;
    state_t      w_state_next;
    logic [27:0] r_hold_cnt;
    logic [1:0]  r_winner;
    logic [8:0]  w_health_l;
    logic [8:0]  w_health_r;
    logic        w_zero_l;
    logic        w_zero_r;
    logic        w_fight;
    logic        w_reload;
    logic        w_ko_release;
    logic        w_hold_done;

    assign w_fight      = (r_state == ST_FIGHT);
    assign w_reload     = hm.round_start &&
                          ((r_state == ST_IDLE) || (r_state == ST_ROUND_OVER));
    // Only players that were knocked out must see their animated bar drain
    assign w_ko_release = (!w_zero_l || (hm.final_health_l == '0)) &&
                          (!w_zero_r || (hm.final_health_r == '0));
    assign w_hold_done  = (r_hold_cnt == KO_HOLD_CYCLES - 28'd1);

    player_health #(
        .MAX_HEALTH(MAX_HEALTH), .DMG_PUNCH(DMG_PUNCH), .DMG_KICK(DMG_KICK),
        .DMG_SPECIAL(DMG_SPECIAL), .IFRAME_CYCLES(IFRAME_CYCLES)
    ) u_player_l (
        .clk(clk), .reset_n(reset_n), .hit(hm.hit_l), .atk(hm.atk_l),
        .block(hm.block_l), .enable(w_fight), .reload(w_reload),
        .health(w_health_l), .is_zero(w_zero_l)
    );

    player_health #(
        .MAX_HEALTH(MAX_HEALTH), .DMG_PUNCH(DMG_PUNCH), .DMG_KICK(DMG_KICK),
        .DMG_SPECIAL(DMG_SPECIAL), .IFRAME_CYCLES(IFRAME_CYCLES)
    ) u_player_r (
        .clk(clk), .reset_n(reset_n), .hit(hm.hit_r), .atk(hm.atk_r),
        .block(hm.block_r), .enable(w_fight), .reload(w_reload),
        .health(w_health_r), .is_zero(w_zero_r)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (hm.round_start)       w_state_next = ST_FIGHT;
            ST_FIGHT:      if (w_zero_l || w_zero_r) w_state_next = ST_KO_WAIT;
            ST_KO_WAIT:    if (w_ko_release)         w_state_next = ST_KO_HOLD;
            ST_KO_HOLD:    if (w_hold_done)          w_state_next = ST_ROUND_OVER;
            ST_ROUND_OVER: if (hm.round_start)       w_state_next = ST_FIGHT;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_KO_HOLD) && !w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 28'd1;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // {left_dead, right_dead} maps straight onto the winner code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner <= WIN_NONE;
        end else if (w_reload) begin
            r_winner <= WIN_NONE;
        end else if (w_fight && (w_zero_l || w_zero_r)) begin
            r_winner <= {w_zero_l, w_zero_r};
        end
    end

    assign hm.curr_health_l = w_health_l;
    assign hm.curr_health_r = w_health_r;
    assign hm.fight_active  = w_fight;
    assign hm.ko_active     = (r_state == ST_KO_WAIT) || (r_state == ST_KO_HOLD);
    assign hm.round_over    = (r_state == ST_ROUND_OVER);
    assign hm.winner        = r_winner;

endmodule
`default_nettype wire
